// File: rtl/register_file_mp_if.sv
// register_file_mp_if
//   Bundles the register-file bus: two write ports, packed read addresses/data,
//   the busy-scoreboard set request and per-read busy flags.
//   master : issue/writeback side (drives writes, reads, busy set)
//   slave  : the register file
interface register_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);
  logic                     write0;
  logic [AW-1:0]            inaddr_w0;
  logic [XLEN-1:0]          indata_w0;
  logic                     write1;
  logic [AW-1:0]            inaddr_w1;
  logic [XLEN-1:0]          indata_w1;
  logic [NUM_RD*AW-1:0]     inaddr_r;
  logic [NUM_RD*XLEN-1:0]   outdata_r;
  logic                     set_busy;
  logic [AW-1:0]            inaddr_busy;
  logic [NUM_RD-1:0]        outbusy_r;

  modport master (
    output write0, inaddr_w0, indata_w0,
    output write1, inaddr_w1, indata_w1,
    output inaddr_r, set_busy, inaddr_busy,
    input  outdata_r, outbusy_r
  );

  modport slave (
    input  write0, inaddr_w0, indata_w0,
    input  write1, inaddr_w1, indata_w1,
    input  inaddr_r, set_busy, inaddr_busy,
    output outdata_r, outbusy_r
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port integer register file with two write ports (port 1 wins on
//   address collision), NUM_RD read ports, optional hardwired x0, optional
//   write-to-read bypass, optional registered reads, and a per-register busy
//   scoreboard used by issue logic for hazard checks.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears registers, busy bits and
//           read pipeline registers
//   bus   : register_file_mp_if slave modport (writes, reads, busy set/flags)
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  register_file_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** AW;

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr_ok0;
  logic wr_ok1;
  logic set_ok;

  // Qualified requests. Gating with rst_n keeps writes (and therefore the
  // bypass path) inert while reset is held, so reads show 0 immediately.
  // With a hardwired x0, anything aimed at address 0 is simply dropped.
  assign wr_ok0 = rst_n && bus.write0 &&
                  !(ZERO_REG && (bus.inaddr_w0 == '0));
  assign wr_ok1 = rst_n && bus.write1 &&
                  !(ZERO_REG && (bus.inaddr_w1 == '0));
  assign set_ok = rst_n && bus.set_busy &&
                  !(ZERO_REG && (bus.inaddr_busy == '0));

  // Port 1 is written after port 0 so its NBA wins a same-address collision.
  // The busy set is last so a new producer overrides a retiring write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok0) begin
        regs[bus.inaddr_w0] <= bus.indata_w0;
        busy[bus.inaddr_w0] <= 1'b0;
      end
      if (wr_ok1) begin
        regs[bus.inaddr_w1] <= bus.indata_w1;
        busy[bus.inaddr_w1] <= 1'b0;
      end
      if (set_ok) begin
        busy[bus.inaddr_busy] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_src;
    logic            hit0;
    logic            hit1;
    logic            hit_set;

    assign ra      = bus.inaddr_r[k*AW +: AW];
    assign hit0    = wr_ok0 && (bus.inaddr_w0 == ra);
    assign hit1    = wr_ok1 && (bus.inaddr_w1 == ra);
    assign hit_set = set_ok && (bus.inaddr_busy == ra);

    always_comb begin
      rd_src = regs[ra];
      if (BYPASS) begin
        if (hit1) begin
          rd_src = bus.indata_w1;
        end else if (hit0) begin
          rd_src = bus.indata_w0;
        end
      end
    end

    // A write landing this cycle retires the producer early unless a new
    // producer is being issued to the same register in the same cycle.
    assign bus.outbusy_r[k] = busy[ra] &
                              ~(BYPASS & (hit0 | hit1) & ~hit_set);

    if (READ_REG) begin : g_reg
      logic [XLEN-1:0] rd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_src;
        end
      end
      assign bus.outdata_r[k*XLEN +: XLEN] = rd_q;
    end else begin : g_comb
      assign bus.outdata_r[k*XLEN +: XLEN] = rd_src;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: combinational read with bypass, 2 read ports
  // dut1: registered read without bypass, 4 read ports
  register_file_mp_if #(.XLEN(32), .AW(5), .NUM_RD(2)) bus0 ();
  register_file_mp_if #(.XLEN(32), .AW(5), .NUM_RD(4)) bus1 ();

  register_file_mp #(.XLEN(32), .AW(5), .NUM_RD(2), .ZERO_REG(1'b1),
                     .BYPASS(1'b1), .READ_REG(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  register_file_mp #(.XLEN(32), .AW(5), .NUM_RD(4), .ZERO_REG(1'b1),
                     .BYPASS(1'b0), .READ_REG(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // reference state
  logic [31:0] mem [32];
  bit          bsy [32];
  logic [31:0] exp1 [4];

  // current stimulus
  bit          w0, w1, sb;
  logic [4:0]  a0, a1, ab;
  logic [31:0] d0, d1;
  logic [4:0]  ra [4];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // What a read should see this cycle, from the architectural rules.
  function automatic logic [31:0] ref_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && w1 && a1 == a) return d1;
    if (byp && w0 && a0 == a) return d0;
    return mem[a];
  endfunction

  function automatic logic [31:0] ref_busy(input logic [4:0] a, input bit byp);
    bit written, setting;
    if (a == 5'd0) return 32'd0;
    written = (w0 && a0 == a) || (w1 && a1 == a);
    setting = sb && ab == a;
    if (byp && written && !setting) return 32'd0;
    return {31'd0, bsy[a]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'd0;
      bsy[i] = 1'b0;
    end
    for (int k = 0; k < 4; k++) exp1[k] = 32'd0;
  endtask

  task automatic set_idle();
    w0 = 0; w1 = 0; sb = 0;
    a0 = '0; a1 = '0; ab = '0;
    d0 = '0; d1 = '0;
    for (int k = 0; k < 4; k++) ra[k] = '0;
  endtask

  task automatic apply();
    bus0.write0 = w0; bus0.inaddr_w0 = a0; bus0.indata_w0 = d0;
    bus0.write1 = w1; bus0.inaddr_w1 = a1; bus0.indata_w1 = d1;
    bus0.set_busy = sb; bus0.inaddr_busy = ab;
    bus1.write0 = w0; bus1.inaddr_w0 = a0; bus1.indata_w0 = d0;
    bus1.write1 = w1; bus1.inaddr_w1 = a1; bus1.indata_w1 = d1;
    bus1.set_busy = sb; bus1.inaddr_busy = ab;
    for (int k = 0; k < 2; k++) bus0.inaddr_r[k*5 +: 5] = ra[k];
    for (int k = 0; k < 4; k++) bus1.inaddr_r[k*5 +: 5] = ra[k];
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d0_rd%0d@%0d", k, ra[k]), bus0.outdata_r[k*32 +: 32], ref_rd(ra[k], 1'b1));
      chk($sformatf("d0_busy%0d@%0d", k, ra[k]), {31'd0, bus0.outbusy_r[k]}, ref_busy(ra[k], 1'b1));
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d1_rd%0d", k), bus1.outdata_r[k*32 +: 32], exp1[k]);
      chk($sformatf("d1_busy%0d@%0d", k, ra[k]), {31'd0, bus1.outbusy_r[k]}, ref_busy(ra[k], 1'b0));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_d0_rd"}, bus0.outdata_r[k*32 +: 32], 32'd0);
      chk({tag, "_d0_busy"}, {31'd0, bus0.outbusy_r[k]}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_d1_rd"}, bus1.outdata_r[k*32 +: 32], 32'd0);
      chk({tag, "_d1_busy"}, {31'd0, bus1.outbusy_r[k]}, 32'd0);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step();
    @(negedge clk);
    apply();
    #1;
    check_outputs();
    @(posedge clk);
    for (int k = 0; k < 4; k++) exp1[k] = mem[ra[k]];
    if (w0 && a0 != 5'd0) begin mem[a0] = d0; bsy[a0] = 1'b0; end
    if (w1 && a1 != 5'd0) begin mem[a1] = d1; bsy[a1] = 1'b0; end
    if (sb && ab != 5'd0) bsy[ab] = 1'b1;
  endtask

  function automatic logic [4:0] rnd_addr();
    // mostly a small window so collisions and hazards actually happen
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rnd_step();
    w0 = 1'($urandom_range(0, 1));
    w1 = 1'($urandom_range(0, 1));
    sb = ($urandom_range(0, 2) == 0);
    a0 = rnd_addr(); a1 = rnd_addr(); ab = rnd_addr();
    d0 = $urandom; d1 = $urandom;
    for (int k = 0; k < 4; k++) ra[k] = rnd_addr();
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    for (int k = 0; k < 4; k++) ra[k] = 5'($urandom_range(1, 7));
    apply();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    clear_model();
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_model();
    set_idle();
    apply();
    #3;
    check_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // single write, read same address same cycle
    set_idle(); w0 = 1; a0 = 5'd1; d0 = 32'h0000ffff; ra[0] = 5'd1; ra[1] = 5'd1;
    step();
    set_idle(); ra[0] = 5'd1; ra[2] = 5'd1;
    step(); step();

    // same-address collision
    set_idle(); w0 = 1; a0 = 5'd5; d0 = 32'hAAAA0000; w1 = 1; a1 = 5'd5; d1 = 32'h5555FFFF;
    ra[0] = 5'd5; ra[1] = 5'd5; ra[3] = 5'd5;
    step();
    set_idle(); ra[0] = 5'd5; ra[1] = 5'd5;
    step(); step();

    // x0 stays zero and never busy
    set_idle(); w0 = 1; a0 = 5'd0; d0 = 32'hDEADBEEF; w1 = 1; a1 = 5'd0; d1 = 32'hDEADBEEF;
    sb = 1; ab = 5'd0;
    step();
    set_idle();
    step(); step();

    // scoreboard on register 7
    set_idle(); sb = 1; ab = 5'd7; ra[0] = 5'd7; ra[1] = 5'd7;
    step();
    set_idle(); ra[0] = 5'd7; ra[1] = 5'd7;
    step();
    set_idle(); w0 = 1; a0 = 5'd7; d0 = 32'h12345678; ra[0] = 5'd7; ra[1] = 5'd7;
    step();
    set_idle(); ra[0] = 5'd7; ra[1] = 5'd7;
    step();
    set_idle(); sb = 1; ab = 5'd7; ra[0] = 5'd7;
    step();
    set_idle(); sb = 1; ab = 5'd7; w1 = 1; a1 = 5'd7; d1 = 32'h0BADF00D; ra[0] = 5'd7; ra[1] = 5'd7;
    step();
    set_idle(); ra[0] = 5'd7; ra[1] = 5'd7;
    step();

    // streaming distinct addresses through the registered-read instance
    for (int i = 0; i < 6; i++) begin
      set_idle(); w0 = 1; a0 = 5'(i + 1); d0 = 32'hC0DE0000 + 32'(i);
      for (int k = 0; k < 4; k++) ra[k] = 5'((i + k) % 8);
      step();
    end

    for (int i = 0; i < 250; i++) rnd_step();
    do_reset();
    for (int i = 0; i < 250; i++) rnd_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
